lsu: RTL and testbench

//  CPU-side load/store unit; initiator for the single-port word RAM (1-cycle registered read, word-only write).

---
 rtl/lsu_pkg.sv | 36 +++
 rtl/lsu_align.sv | 40 ++++
 rtl/lsu.sv | 163 ++++++++++++++++
 tb/tb_lsu.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32 size/sign codes, FSM states, byte-lane masks.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    localparam logic [31:0] LANE_B_MASK = 32'h0000_00FF;
    localparam logic [31:0] LANE_H_MASK = 32'h0000_FFFF;

    typedef enum logic [2:0] {
        IDLE,
        ST_W,
        LD_R,
        LD_D,
        RMW_R,
        RMW_M
    } lsu_state_t;

    // Unsupported codes collapse to a full-word access
    function automatic logic [2:0] norm_f3(input logic is_store, input logic [2:0] f3);
        if (is_store)
            return (f3 == F3_B || f3 == F3_H) ? f3 : F3_W;
        case (f3)
            F3_B, F3_H, F3_BU, F3_HU: return f3;
            default:                  return F3_W;
        endcase
    endfunction

    function automatic logic is_half(input logic [2:0] f3);
        return (f3 == F3_H) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational data path for the LSU: sub-word load extract and read-modify-write merge.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_dout,
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_f3,
    input  logic [15:0] i_wdata,
    output logic [31:0] o_load,
    output logic [31:0] o_merge
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [4:0]  w_shift;
    logic [31:0] w_mask;

    always_comb begin
        w_shift = {i_off, 3'b000};
        w_half  = i_off[1] ? i_dout[31:16] : i_dout[15:0];
        case (i_off)
            2'd0:    w_byte = i_dout[7:0];
            2'd1:    w_byte = i_dout[15:8];
            2'd2:    w_byte = i_dout[23:16];
            default: w_byte = i_dout[31:24];
        endcase

        case (i_f3)
            F3_B:    o_load = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_load = {24'h0, w_byte};
            F3_H:    o_load = {{16{w_half[15]}}, w_half};
            F3_HU:   o_load = {16'h0, w_half};
            default: o_load = i_dout;
        endcase

        w_mask  = (i_f3 == F3_H) ? LANE_H_MASK : LANE_B_MASK;
        o_merge = (i_dout & ~(w_mask << w_shift)) | (({16'h0, i_wdata} & w_mask) << w_shift);
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit FSM driving a single-port word RAM; sub-word stores use read-modify-write.
// Optional LSU_MISALIGN_CHECK_EN: misaligned H/W accesses complete at once with err instead of being masked.
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 30
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    output logic              ready,
    input  logic              we,
    input  logic [2:0]        funct3,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    output logic              mem_re,
    output logic              mem_we,
    input  logic [31:0]       mem_dout
);

    lsu_state_t        r_state, w_state_nxt;
    logic              r_done, w_done_nxt;
    logic [31:0]       r_rdata, w_rdata_nxt;
    logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
    logic [31:0]       r_mem_din, w_mem_din_nxt;
    logic              r_mem_re, w_mem_re_nxt;
    logic              r_mem_we, w_mem_we_nxt;
    logic [1:0]        r_off, w_off_nxt;
    logic [2:0]        r_f3, w_f3_nxt;
    logic [15:0]       r_wdata, w_wdata_nxt;

    logic [2:0]        w_f3;
    logic [1:0]        w_off;
    logic              w_mis;
    logic [31:0]       w_load;
    logic [31:0]       w_merge;

    assign w_f3  = norm_f3(we, funct3);
    assign w_off = (w_f3 == F3_W) ? 2'b00 :
                   is_half(w_f3)  ? {addr[1], 1'b0} : addr[1:0];

`ifdef LSU_MISALIGN_CHECK_EN
    logic r_err, w_err_nxt;
    assign w_mis = (is_half(w_f3) && addr[0]) || ((w_f3 == F3_W) && (addr[1:0] != 2'b00));
    assign err   = r_err;
`else
    assign w_mis = 1'b0;
    assign err   = 1'b0;
`endif

    lsu_align u_align (
        .i_dout  (mem_dout),
        .i_off   (r_off),
        .i_f3    (r_f3),
        .i_wdata (r_wdata),
        .o_load  (w_load),
        .o_merge (w_merge)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_done_nxt     = 1'b0;
        w_rdata_nxt    = r_rdata;
        w_mem_addr_nxt = r_mem_addr;
        w_mem_din_nxt  = r_mem_din;
        w_mem_re_nxt   = 1'b0;
        w_mem_we_nxt   = 1'b0;
        w_off_nxt      = r_off;
        w_f3_nxt       = r_f3;
        w_wdata_nxt    = r_wdata;
`ifdef LSU_MISALIGN_CHECK_EN
        w_err_nxt      = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (req) begin
                    if (w_mis) begin
                        w_done_nxt = 1'b1;
`ifdef LSU_MISALIGN_CHECK_EN
                        w_err_nxt  = 1'b1;
`endif
                    end else begin
                        w_mem_addr_nxt = addr[ADDR_W+1:2];
                        w_off_nxt      = w_off;
                        w_f3_nxt       = w_f3;
                        w_wdata_nxt    = wdata[15:0];
                        if (we && (w_f3 == F3_W)) begin
                            w_mem_we_nxt  = 1'b1;
                            w_mem_din_nxt = wdata;
                            w_state_nxt   = ST_W;
                        end else begin
                            w_mem_re_nxt  = 1'b1;
                            w_state_nxt   = we ? RMW_R : LD_R;
                        end
                    end
                end
            end
            ST_W: begin
                w_done_nxt  = 1'b1;
                w_state_nxt = IDLE;
            end
            LD_R:  w_state_nxt = LD_D;
            LD_D: begin
                w_rdata_nxt = w_load;
                w_done_nxt  = 1'b1;
                w_state_nxt = IDLE;
            end
            RMW_R: w_state_nxt = RMW_M;
            RMW_M: begin
                w_mem_din_nxt = w_merge;
                w_mem_we_nxt  = 1'b1;
                w_state_nxt   = ST_W;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_done     <= 1'b0;
            r_rdata    <= '0;
            r_mem_addr <= '0;
            r_mem_din  <= '0;
            r_mem_re   <= 1'b0;
            r_mem_we   <= 1'b0;
            r_off      <= '0;
            r_f3       <= '0;
            r_wdata    <= '0;
`ifdef LSU_MISALIGN_CHECK_EN
            r_err      <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_done     <= w_done_nxt;
            r_rdata    <= w_rdata_nxt;
            r_mem_addr <= w_mem_addr_nxt;
            r_mem_din  <= w_mem_din_nxt;
            r_mem_re   <= w_mem_re_nxt;
            r_mem_we   <= w_mem_we_nxt;
            r_off      <= w_off_nxt;
            r_f3       <= w_f3_nxt;
            r_wdata    <= w_wdata_nxt;
`ifdef LSU_MISALIGN_CHECK_EN
            r_err      <= w_err_nxt;
`endif
        end
    end

    assign ready    = (r_state == IDLE);
    assign done     = r_done;
    assign rdata    = r_rdata;
    assign mem_addr = r_mem_addr;
    assign mem_din  = r_mem_din;
    assign mem_re   = r_mem_re;
    assign mem_we   = r_mem_we;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu against a 16-word RAM model with word 4 preloaded to 0x8899AABB.
module tb_lsu;
    import lsu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic        ready;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        done;
    logic [31:0] rdata;
    logic        err;
    logic [29:0] mem_addr;
    logic [31:0] mem_din;
    logic        mem_re;
    logic        mem_we;
    logic [31:0] mem_dout;

    int unsigned n_checks;
    int unsigned n_errors;
    int unsigned we_total;
    int unsigned overlap;
    logic        ram_load;
    logic [31:0] ram [0:15];

    lsu #(.ADDR_W(30)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .ready    (ready),
        .we       (we),
        .funct3   (funct3),
        .addr     (addr),
        .wdata    (wdata),
        .done     (done),
        .rdata    (rdata),
        .err      (err),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_re   (mem_re),
        .mem_we   (mem_we),
        .mem_dout (mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_load) begin
            for (int i = 0; i < 16; i++) ram[i] <= 32'h0;
            ram[4] <= 32'h8899_AABB;
        end else begin
            if (mem_we) ram[mem_addr[3:0]] <= mem_din;
            if (mem_re) mem_dout <= ram[mem_addr[3:0]];
        end
    end

    always @(negedge clk) begin
        if (mem_we) we_total++;
        if (mem_re && mem_we) overlap++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Launch one access, then scramble the request fields to prove they are ignored after accept
    task automatic run_op(input string tag, input logic w, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int unsigned lat, input int unsigned re_at, input int unsigned we_at,
                          input logic [29:0] exp_maddr, input logic [31:0] exp_din,
                          input logic [31:0] exp_rd, input logic exp_err);
        int unsigned done_at, re_k, we_k, re_n, we_n;
        logic [29:0] maddr;
        logic [31:0] din, rd;
        logic        e;
        done_at = 0; re_k = 0; we_k = 0; re_n = 0; we_n = 0;
        maddr = '0; din = '0; rd = '0; e = 1'b0;
        @(negedge clk);
        check({tag, ".ready"}, {31'b0, ready}, 32'd1);
        req = 1'b1; we = w; funct3 = f3; addr = a; wdata = wd;
        for (int unsigned k = 1; k <= 8 && done_at == 0; k++) begin
            @(negedge clk);
            req = 1'b0; we = ~w; funct3 = 3'd7; addr = ~a; wdata = ~wd;
            if (mem_re) begin re_n++; re_k = k; maddr = mem_addr; end
            if (mem_we) begin we_n++; we_k = k; maddr = mem_addr; din = mem_din; end
            if (done) begin done_at = k; rd = rdata; e = err; end
        end
        check({tag, ".done_lat"}, done_at, lat);
        check({tag, ".re_at"}, re_k, re_at);
        check({tag, ".we_at"}, we_k, we_at);
        check({tag, ".re_cnt"}, re_n, (re_at != 0) ? 32'd1 : 32'd0);
        check({tag, ".we_cnt"}, we_n, (we_at != 0) ? 32'd1 : 32'd0);
        if (re_at != 0 || we_at != 0) check({tag, ".maddr"}, {2'b0, maddr}, {2'b0, exp_maddr});
        if (we_at != 0) check({tag, ".din"}, din, exp_din);
        check({tag, ".rdata"}, rd, exp_rd);
        check({tag, ".err"}, {31'b0, e}, {31'b0, exp_err});
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".ready"},  {31'b0, ready},  32'd1);
        check({tag, ".done"},   {31'b0, done},   32'd0);
        check({tag, ".err"},    {31'b0, err},    32'd0);
        check({tag, ".mem_re"}, {31'b0, mem_re}, 32'd0);
        check({tag, ".mem_we"}, {31'b0, mem_we}, 32'd0);
        check({tag, ".rdata"},  rdata,           32'd0);
        check({tag, ".maddr"},  {2'b0, mem_addr}, 32'd0);
        check({tag, ".din"},    mem_din,         32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned dk [3];
        logic [31:0] rdv [3];
        int unsigned idx;
        int unsigned we_snap;

        n_checks = 0; n_errors = 0; we_total = 0; overlap = 0;
        rst_n = 1'b0; ram_load = 1'b1;
        req = 1'b0; we = 1'b0; funct3 = 3'd0; addr = '0; wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1; ram_load = 1'b0;
        @(negedge clk);
        check_reset_outputs("post_rst");

        //      tag     we    f3     addr    wdata          lat re we maddr din  rdata          err
        run_op("lb11",  1'b0, F3_B,  32'h11, 32'h0,         3, 1, 0, 30'd4, 0, 32'hFFFF_FFAA, 1'b0);
        run_op("lbu13", 1'b0, F3_BU, 32'h13, 32'h0,         3, 1, 0, 30'd4, 0, 32'h0000_0088, 1'b0);
        run_op("lhu12", 1'b0, F3_HU, 32'h12, 32'h0,         3, 1, 0, 30'd4, 0, 32'h0000_8899, 1'b0);
        run_op("lh12",  1'b0, F3_H,  32'h12, 32'h0,         3, 1, 0, 30'd4, 0, 32'hFFFF_8899, 1'b0);
        run_op("lw10",  1'b0, F3_W,  32'h10, 32'h0,         3, 1, 0, 30'd4, 0, 32'h8899_AABB, 1'b0);
        run_op("lh10",  1'b0, F3_H,  32'h10, 32'h0,         3, 1, 0, 30'd4, 0, 32'hFFFF_AABB, 1'b0);
`ifdef LSU_MISALIGN_CHECK_EN
        run_op("lw12",  1'b0, F3_W,  32'h12, 32'h0,         1, 0, 0, 30'd0, 0, 32'hFFFF_AABB, 1'b1);
`else
        run_op("lw12",  1'b0, F3_W,  32'h12, 32'h0,         3, 1, 0, 30'd4, 0, 32'h8899_AABB, 1'b0);
`endif

        // SB to word 4, reset asserted while the FSM sits in RMW_M
        we_snap = we_total;
        @(negedge clk);
        req = 1'b1; we = 1'b1; funct3 = F3_B; addr = 32'h10; wdata = 32'h0000_0011;
        @(negedge clk);
        req = 1'b0;
        check("rmw_rst.re", {31'b0, mem_re}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rmw_rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rmw_rst.we_never", we_total, we_snap);
        check("rmw_rst.word4", ram[4], 32'h8899_AABB);
        check_reset_outputs("rmw_rst_after");

        run_op("sh12",  1'b1, F3_H,  32'h12, 32'h5555_1234, 4, 1, 3, 30'd4, 32'h1234_AABB, 32'h0,          1'b0);
        run_op("lw10b", 1'b0, F3_W,  32'h10, 32'h0,         3, 1, 0, 30'd4, 0,             32'h1234_AABB, 1'b0);
        run_op("sw14",  1'b1, F3_W,  32'h14, 32'hCAFE_F00D, 2, 0, 1, 30'd5, 32'hCAFE_F00D, 32'h1234_AABB, 1'b0);
        run_op("lb17",  1'b0, F3_B,  32'h17, 32'h0,         3, 1, 0, 30'd5, 0,             32'hFFFF_FFCA, 1'b0);
        run_op("lbu15", 1'b0, F3_BU, 32'h15, 32'h0,         3, 1, 0, 30'd5, 0,             32'h0000_00F0, 1'b0);
        run_op("lf3_3", 1'b0, 3'd3,  32'h14, 32'h0,         3, 1, 0, 30'd5, 0,             32'hCAFE_F00D, 1'b0);
        run_op("sb15",  1'b1, F3_B,  32'h15, 32'hAAAA_AA77, 4, 1, 3, 30'd5, 32'hCAFE_770D, 32'hCAFE_F00D, 1'b0);
        run_op("sf3_5", 1'b1, 3'd5,  32'h18, 32'h0102_0304, 2, 0, 1, 30'd6, 32'h0102_0304, 32'hCAFE_F00D, 1'b0);
        run_op("lhu1a", 1'b0, F3_HU, 32'h1A, 32'h0,         3, 1, 0, 30'd6, 0,             32'h0000_0102, 1'b0);
        run_op("lh16",  1'b0, F3_H,  32'h16, 32'h0,         3, 1, 0, 30'd5, 0,             32'hFFFF_CAFE, 1'b0);

        // Back-to-back LW, SW, LB with req held high; each next op is presented in the done cycle
        for (int i = 0; i < 3; i++) begin dk[i] = 0; rdv[i] = '0; end
        idx = 0;
        @(negedge clk);
        req = 1'b1; we = 1'b0; funct3 = F3_W; addr = 32'h10; wdata = 32'h0;
        for (int unsigned k = 1; k <= 20 && idx < 3; k++) begin
            @(negedge clk);
            if (done) begin
                dk[idx]  = k;
                rdv[idx] = rdata;
                check("b2b.ready_at_done", {31'b0, ready}, 32'd1);
                idx++;
                case (idx)
                    1: begin we = 1'b1; funct3 = F3_W; addr = 32'h14; wdata = 32'h0000_00F0; end
                    2: begin we = 1'b0; funct3 = F3_B; addr = 32'h14; wdata = 32'h0; end
                    default: req = 1'b0;
                endcase
            end
        end
        req = 1'b0;
        check("b2b.lw_done",  dk[0], 32'd3);
        check("b2b.sw_done",  dk[1], 32'd5);
        check("b2b.lb_done",  dk[2], 32'd8);
        check("b2b.lw_rdata", rdv[0], 32'h1234_AABB);
        check("b2b.lb_rdata", rdv[2], 32'hFFFF_FFF0);

        check("re_we_overlap", overlap, 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
